// File: rtl/graph_pkg.sv
// Shared constants, FSM state encoding and edge RAM word layout
// for the path decoder.
package graph_pkg;

  localparam int EDGE_NUM  = 1034;
  localparam int EDGE_AW   = 11;
  localparam int POSE_W    = 8;
  localparam int MAX_LEVEL = 10;
  localparam int SEL_W     = MAX_LEVEL * EDGE_AW;

  typedef enum logic [2:0] {
    IDLE,
    EMIT0,
    FETCH,
    WAIT,
    NEXT,
    EMIT,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic [POSE_W-1:0] first;
    logic [POSE_W-1:0] second;
  } edge_word_t;

  function automatic logic [EDGE_AW-1:0] slot_of(
    input logic [SEL_W-1:0] sel,
    input logic [3:0]       idx
  );
    return sel[int'(idx)*EDGE_AW +: EDGE_AW];
  endfunction

endpackage

// File: rtl/path_decoder_pose_out_reg.sv
// Valid/ready output holding register: data and last stay
// frozen while a loaded pose waits for the consumer.
module pose_out_reg
  import graph_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [POSE_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [POSE_W-1:0] data,
  output logic              last
);

  logic              valid_q, valid_d;
  logic [POSE_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;

endmodule

// File: rtl/path_decoder.sv
// Walks the selected edge chain from endPose back to startPose and streams poses.
// Define PATH_DECODER_CHECK_EN to reject broken chains, self-loops and wrong endpoints.
module path_decoder
  import graph_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               start,
  input  logic [3:0]         levelCnt,
  input  logic [POSE_W-1:0]  startPose,
  input  logic [POSE_W-1:0]  endPose,
  input  logic [SEL_W-1:0]   selectEdge,
  output logic [EDGE_AW-1:0] ramAddress,
  input  logic [15:0]        RAMData,
  output logic               pose_valid,
  input  logic               pose_ready,
  output logic [POSE_W-1:0]  pose_data,
  output logic               pose_last,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_t             state_q, state_d;
  logic [3:0]         lvl_q, lvl_d;
  logic [3:0]         lvl_cnt_q, lvl_cnt_d;
  logic [POSE_W-1:0]  cur_q, cur_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [EDGE_AW-1:0] addr_q, addr_d;
  logic               err_q, err_d;

  logic               load, load_last, hs, is_last, bad;
  logic [POSE_W-1:0]  load_data, nxt;
  logic [EDGE_AW-1:0] idx;
  edge_word_t         word;

  assign word    = edge_word_t'(RAMData);
  assign hs      = pose_valid & pose_ready;
  assign idx     = slot_of(sel_q, lvl_q);
  assign nxt     = (word.first == cur_q) ? word.second : word.first;
  assign is_last = (lvl_q == lvl_cnt_q - 4'd1);

`ifdef PATH_DECODER_CHECK_EN
  logic [POSE_W-1:0] spose_q, spose_d;

  assign spose_d = (state_q == IDLE && start) ? startPose : spose_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) spose_q <= '0;
    else        spose_q <= spose_d;
  end

  // Endpoint mismatch is caught here so the wrong pose never reaches the stream.
  assign bad = (word.first != cur_q && word.second != cur_q) ||
               (word.first == word.second) ||
               (is_last && nxt != spose_q);
`else
  logic unused_start_pose;

  assign unused_start_pose = ^startPose;
  assign bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    lvl_cnt_d = lvl_cnt_q;
    cur_d     = cur_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    err_d     = err_q;
    load      = 1'b0;
    load_data = cur_q;
    load_last = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d     = 1'b0;
          lvl_d     = '0;
          lvl_cnt_d = levelCnt;
          sel_d     = selectEdge;
          cur_d     = endPose;
          if (levelCnt == 4'd0 || int'(levelCnt) > MAX_LEVEL) begin
            state_d = ERR;
          end else begin
            state_d   = EMIT0;
            load      = 1'b1;
            load_data = endPose;
          end
        end
      end
      EMIT0: if (hs) state_d = FETCH;
      FETCH: begin
        if (int'(idx) >= EDGE_NUM) begin
          state_d = ERR;
        end else begin
          addr_d  = idx;
          state_d = WAIT;
        end
      end
      WAIT: state_d = NEXT;
      NEXT: begin
        cur_d = nxt;
        if (bad) begin
          state_d = ERR;
        end else begin
          state_d   = EMIT;
          load      = 1'b1;
          load_data = nxt;
          load_last = is_last;
        end
      end
      EMIT: begin
        if (hs) begin
          if (pose_last) begin
            state_d = DONE;
          end else begin
            lvl_d   = lvl_q + 4'd1;
            state_d = FETCH;
          end
        end
      end
      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
    endcase
    if (state_d == ERR) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      lvl_cnt_q <= '0;
      cur_q     <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      lvl_cnt_q <= lvl_cnt_d;
      cur_q     <= cur_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  pose_out_reg u_out (
    .clk       (CLK),
    .rst_n     (RST_n),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .ready     (pose_ready),
    .valid     (pose_valid),
    .data      (pose_data),
    .last      (pose_last)
  );

  assign ramAddress = addr_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign error      = err_q;

endmodule
